mem_arbiter: RTL

- Two-master, one-slave arbiter on the 32-bit sel/ready memory bus. Sits directly upstream of the block RAM (and any other bus slave).
- Shares that slave between the CPU instruction-fetch port and the data load/store port.
- Round-robin on conflicts; holds a grant until the slave signals ready.
- A per-transfer watchdog terminates hung transfers with a fault pulse.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sel/ready memory slave between the instruction-fetch port and the
// data load/store port. Conflicts are resolved round-robin. A grant is held until the slave
// returns ready. A watchdog ends a hung transfer with a zero-data ready and a fault pulse.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   instr_*                  fetch master (address, sel in; read value, ready out)
//   data_*                   load/store master (address, sel, mask, write value in;
//                            read value, ready out)
//   mem_*                    slave side (address, sel, mask, write value out;
//                            read value, ready in)
//   fault_out                one-cycle pulse when the watchdog terminates a transfer
//
// TIMEOUT is the number of grant cycles a transfer may wait for mem_ready_in. It must be in
// the range 2..255 because the watchdog is eight bits wide.

module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_sel_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_sel_in,
  output logic [31:0] data_read_value_out,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic        data_ready_out,
  output logic [31:0] mem_address_out,
  output logic        mem_sel_out,
  input  logic [31:0] mem_read_value_in,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic        mem_ready_in,
  output logic        fault_out
);

  typedef enum logic [1:0] {StIdle, StGrantInstr, StGrantData} state_e;

  localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

  state_e     state;
  logic       last_grant_data;
  logic [7:0] watchdog;

  logic granted_sel;
  logic in_grant;
  logic complete;
  logic expire;
  logic finish;

  // Slave-side mux follows the current grant; idle drives zeros.
  always_comb begin
    mem_address_out     = '0;
    mem_write_mask_out  = '0;
    mem_write_value_out = '0;
    granted_sel         = 1'b0;
    unique case (state)
      StGrantInstr: begin
        mem_address_out = instr_address_in;
        granted_sel     = instr_sel_in;
      end
      StGrantData: begin
        mem_address_out     = data_address_in;
        mem_write_mask_out  = data_write_mask_in;
        mem_write_value_out = data_write_value_in;
        granted_sel         = data_sel_in;
      end
      default: ;
    endcase
    mem_sel_out = granted_sel && !reset;
  end

  assign in_grant = (state != StIdle) && !reset;
  assign complete = in_grant && mem_ready_in;
  // A slave ready in the timeout cycle wins, and an aborted request never times out.
  assign expire   = in_grant && !mem_ready_in && granted_sel && (watchdog == TimeoutCount);
  assign finish   = complete || expire;

  assign instr_ready_out      = finish && (state == StGrantInstr);
  assign data_ready_out       = finish && (state == StGrantData);
  assign instr_read_value_out = (complete && (state == StGrantInstr)) ? mem_read_value_in : '0;
  assign data_read_value_out  = (complete && (state == StGrantData)) ? mem_read_value_in : '0;
  assign fault_out            = expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= StIdle;
      last_grant_data <= 1'b1;
      watchdog        <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          watchdog <= '0;
          if (instr_sel_in && data_sel_in) begin
            state <= last_grant_data ? StGrantInstr : StGrantData;
          end else if (instr_sel_in) begin
            state <= StGrantInstr;
          end else if (data_sel_in) begin
            state <= StGrantData;
          end
        end
        default: begin
          if (finish) begin
            // Always pass through idle so mem_sel_out drops between transfers.
            state           <= StIdle;
            last_grant_data <= (state == StGrantData);
            watchdog        <= '0;
          end else if (!granted_sel) begin
            // Master withdrew its request: drop silently, keep round-robin history.
            state    <= StIdle;
            watchdog <= '0;
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
